// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: ALU operation codes, major opcodes, funct7 values
// and the issue-FSM state encoding.
package rv32i_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ALUOP_W = 3;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b100;
   localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b101;
   localparam logic [ALUOP_W-1:0] ALU_SRL = 3'b110;
   localparam logic [ALUOP_W-1:0] ALU_SRA = 3'b111;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_WB     = 2'd3
   } state_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// Integer register file for alu_issue.
//   clk, rst        : clock, synchronous active-high clear of every register
//   ra1/rd1, ra2/rd2: combinational operand read ports
//   dbg_addr/dbg_data: combinational debug read port
//   we, wa, wd      : synchronous write port; writes to x0 are dropped
// x0 reads as zero on every port.
module alu_issue_regfile #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra1,
   output logic [XLEN-1:0]   rd1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [XLEN-1:0]   rd2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [XLEN-1:0]   dbg_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [XLEN-1:0]   wd
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   // Next-state of the array: single write port, x0 never written.
   always_comb begin
      regs_d = regs_q;
      if (we && (wa != '0)) regs_d[wa] = wd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd1      = (ra1 == '0)      ? '0 : regs_q[ra1];
   assign rd2      = (ra2 == '0)      ? '0 : regs_q[ra2];
   assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts one RV32I R-type / OP-IMM instruction per handshake,
// decodes it, drives the external combinational ALU and writes the result back.
//   instr_valid/instr_ready/instr : instruction handshake (ready only in IDLE)
//   alu_a/alu_b/alu_op            : registered ALU operands and operation
//   alu_result                    : combinational ALU result, written in WB
//   done_valid/done_rd            : 1-cycle writeback pulse with destination
//   illegal                       : 1-cycle pulse for an unsupported instruction
//   dbg_addr/dbg_data             : combinational register debug read
// Build option: define ALU_ISSUE_SRA_EN to support SRA/SRAI (alu_op 111);
// otherwise they decode as illegal.
module alu_issue
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [INSTR_W-1:0]    instr,
   output logic [XLEN-1:0]       alu_a,
   output logic [XLEN-1:0]       alu_b,
   output logic [ALUOP_W-1:0]    alu_op,
   input  logic [XLEN-1:0]       alu_result,
   output logic                  done_valid,
   output logic [REG_ADDR_W-1:0] done_rd,
   output logic                  illegal,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [XLEN-1:0]       dbg_data
);

   state_t                state_q, state_d;
   logic [INSTR_W-1:0]    instr_q, instr_d;
   logic                  instr_ready_q, instr_ready_d;
   logic [XLEN-1:0]       alu_a_q, alu_a_d;
   logic [XLEN-1:0]       alu_b_q, alu_b_d;
   logic [ALUOP_W-1:0]    alu_op_q, alu_op_d;
   logic                  done_valid_q, done_valid_d;
   logic [REG_ADDR_W-1:0] done_rd_q, done_rd_d;
   logic                  illegal_q, illegal_d;

   logic [6:0]            opcode, funct7;
   logic [2:0]            funct3;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic [XLEN-1:0]       rs1_data, rs2_data, imm_sext, shamt_zext;
   logic                  dec_ok;
   logic [ALUOP_W-1:0]    dec_op;
   logic [XLEN-1:0]       dec_b;
   logic                  we_c;

   assign opcode     = instr_q[6:0];
   assign rd         = REG_ADDR_W'(instr_q[11:7]);
   assign funct3     = instr_q[14:12];
   assign rs1        = REG_ADDR_W'(instr_q[19:15]);
   assign rs2        = REG_ADDR_W'(instr_q[24:20]);
   assign funct7     = instr_q[31:25];
   assign imm_sext   = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
   assign shamt_zext = {{(XLEN-5){1'b0}}, instr_q[24:20]};

   alu_issue_regfile #(
      .XLEN   (XLEN),
      .ADDR_W (REG_ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .ra1      (rs1),
      .rd1      (rs1_data),
      .ra2      (rs2),
      .rd2      (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (we_c),
      .wa       (rd),
      .wd       (alu_result)
   );

   // Instruction decode from the latched word.
   always_comb begin
      dec_ok = 1'b0;
      dec_op = ALU_ADD;
      dec_b  = rs2_data;
      case (opcode)
         OPC_OP: begin
            dec_b = rs2_data;
            if (funct7 == F7_BASE) begin
               dec_ok = 1'b1;
               case (funct3)
                  3'b000:  dec_op = ALU_ADD;
                  3'b001:  dec_op = ALU_SLL;
                  3'b100:  dec_op = ALU_XOR;
                  3'b101:  dec_op = ALU_SRL;
                  3'b110:  dec_op = ALU_OR;
                  3'b111:  dec_op = ALU_AND;
                  default: dec_ok = 1'b0;
               endcase
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000) begin
                  dec_ok = 1'b1;
                  dec_op = ALU_SUB;
               end
`ifdef ALU_ISSUE_SRA_EN
               if (funct3 == 3'b101) begin
                  dec_ok = 1'b1;
                  dec_op = ALU_SRA;
               end
`endif
            end
         end
         OPC_OPIMM: begin
            dec_b = imm_sext;
            case (funct3)
               3'b000: begin dec_ok = 1'b1; dec_op = ALU_ADD; end
               3'b100: begin dec_ok = 1'b1; dec_op = ALU_XOR; end
               3'b110: begin dec_ok = 1'b1; dec_op = ALU_OR;  end
               3'b111: begin dec_ok = 1'b1; dec_op = ALU_AND; end
               3'b001: begin
                  dec_b  = shamt_zext;
                  dec_op = ALU_SLL;
                  dec_ok = (funct7 == F7_BASE);
               end
               3'b101: begin
                  dec_b = shamt_zext;
                  if (funct7 == F7_BASE) begin
                     dec_ok = 1'b1;
                     dec_op = ALU_SRL;
                  end
`ifdef ALU_ISSUE_SRA_EN
                  else if (funct7 == F7_ALT) begin
                     dec_ok = 1'b1;
                     dec_op = ALU_SRA;
                  end
`endif
               end
               default: dec_ok = 1'b0;
            endcase
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // Issue FSM next-state and registered outputs.
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      done_valid_d = 1'b0;
      done_rd_d    = done_rd_q;
      illegal_d    = 1'b0;
      we_c         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid && instr_ready_q) begin
               instr_d = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_ok) begin
               alu_a_d  = rs1_data;
               alu_b_d  = dec_b;
               alu_op_d = dec_op;
               state_d  = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_EXEC: begin
            // Raise done so it coincides with the WB-cycle write.
            done_valid_d = 1'b1;
            done_rd_d    = rd;
            state_d      = S_WB;
         end
         S_WB: begin
            we_c    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      instr_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         instr_q       <= '0;
         instr_ready_q <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= ALU_ADD;
         done_valid_q  <= 1'b0;
         done_rd_q     <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_ready_q <= instr_ready_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         done_valid_q  <= done_valid_d;
         done_rd_q     <= done_rd_d;
         illegal_q     <= illegal_d;
      end
   end

   assign instr_ready = instr_ready_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign done_valid  = done_valid_q;
   assign done_rd     = done_rd_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, handshake driver,
// instruction vector table with an expectation queue and a register model.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic        done_valid;
   logic [4:0]  done_rd;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   alu_issue dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .done_valid  (done_valid),
      .done_rd     (done_rd),
      .illegal     (illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural ALU
   always_comb begin
      case (alu_op)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = alu_a & alu_b;
         3'b011:  alu_result = alu_a | alu_b;
         3'b100:  alu_result = alu_a ^ alu_b;
         3'b101:  alu_result = alu_a << alu_b[4:0];
         3'b110:  alu_result = alu_a >> alu_b[4:0];
         default: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      endcase
   end

   typedef struct {
      string       name;
      logic [31:0] instr;
      bit          ill;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [2:0]  op;
   } vec_t;

   vec_t        vecs[$];
   vec_t        sb_q[$];
   logic [31:0] mregs [32];
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   bit          saw_op7 = 1'b0;

   always @(posedge clk) begin
      if (done_valid) done_cnt <= done_cnt + 1;
      if (alu_op == 3'b111) saw_op7 <= 1'b1;
   end

   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic vec_t mk(input string n, input logic [31:0] i, input bit il,
                               input logic [4:0] rd, input logic [31:0] v,
                               input logic [2:0] op);
      vec_t t;
      t.name = n; t.instr = i; t.ill = il; t.rd = rd; t.val = v; t.op = op;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one instruction, then follow it to its done or illegal pulse.
   task automatic issue(input vec_t v);
      int   cyc;
      bit   seen;
      vec_t e;
      cyc = 0;
      while (!instr_ready && cyc < 10) begin
         @(posedge clk); #1; cyc++;
      end
      chk({v.name, ".ready"}, 32'(instr_ready), 32'd1);
      instr       = v.instr;
      instr_valid = 1'b1;
      sb_q.push_back(v);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = '0;
      chk({v.name, ".busy"}, 32'(instr_ready), 32'd0);
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc < 8) begin
         if (done_valid || illegal) seen = 1'b1;
         else begin
            @(posedge clk); #1; cyc++;
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s.timeout: no done/illegal within %0d cycles", v.name, cyc);
         void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s.scoreboard: output with empty expectation queue", v.name);
      end else begin
         e = sb_q.pop_front();
         chk({e.name, ".latency"}, 32'(cyc), e.ill ? 32'd2 : 32'd3);
         chk({e.name, ".illegal"}, 32'(illegal), 32'(e.ill));
         chk({e.name, ".done"}, 32'(done_valid), 32'(!e.ill));
         if (!e.ill) begin
            chk({e.name, ".done_rd"}, 32'(done_rd), 32'(e.rd));
            chk({e.name, ".alu_op"}, 32'(alu_op), 32'(e.op));
            dbg_addr = e.rd; #1;
            chk({e.name, ".dbg_pre"}, dbg_data, mregs[e.rd]);
            exp_done++;
            if (e.rd != 5'd0) mregs[e.rd] = e.val;
         end else begin
            chk({e.name, ".ill_ready"}, 32'(instr_ready), 32'd1);
         end
         @(posedge clk); #1;
         chk({e.name, ".pulse_end"}, {30'd0, done_valid, illegal}, 32'd0);
         chk({e.name, ".ready_ret"}, 32'(instr_ready), 32'd1);
         dbg_addr = e.rd; #1;
         chk({e.name, ".dbg_post"}, dbg_data, mregs[e.rd]);
      end
   endtask

   initial begin
      bit sra_en;
`ifdef ALU_ISSUE_SRA_EN
      sra_en = 1'b1;
`else
      sra_en = 1'b0;
`endif
      for (int i = 0; i < 32; i++) mregs[i] = '0;

      vecs.push_back(mk("addi_x1", i_t(12'd10, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'd10, 3'b000));
      vecs.push_back(mk("addi_x2", i_t(12'd5, 5'd0, 3'b000, 5'd2), 0, 5'd2, 32'd5, 3'b000));
      vecs.push_back(mk("add_x3", r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 5'd3, 32'd15, 3'b000));
      vecs.push_back(mk("sub_x4", r_t(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 0, 5'd4, 32'd5, 3'b001));
      vecs.push_back(mk("and_x5", r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd5), 0, 5'd5, 32'd0, 3'b010));
      vecs.push_back(mk("or_x6", r_t(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 0, 5'd6, 32'd15, 3'b011));
      vecs.push_back(mk("xor_x7", r_t(7'h00, 5'd2, 5'd1, 3'b100, 5'd7), 0, 5'd7, 32'd15, 3'b100));
      vecs.push_back(mk("sll_x8", r_t(7'h00, 5'd2, 5'd1, 3'b001, 5'd8), 0, 5'd8, 32'd320, 3'b101));
      vecs.push_back(mk("srl_x9", r_t(7'h00, 5'd2, 5'd1, 3'b101, 5'd9), 0, 5'd9, 32'd0, 3'b110));
      vecs.push_back(mk("addi_x10", i_t(12'hFF8, 5'd0, 3'b000, 5'd10), 0, 5'd10, 32'hFFFF_FFF8, 3'b000));
      vecs.push_back(mk("srai_x11", i_t(12'h401, 5'd10, 3'b101, 5'd11), !sra_en, 5'd11,
                        32'hFFFF_FFFC, 3'b111));
      vecs.push_back(mk("slt_x12", r_t(7'h00, 5'd2, 5'd1, 3'b010, 5'd12), 1, 5'd12, 32'd0, 3'b000));
      vecs.push_back(mk("addi_x0", i_t(12'd7, 5'd0, 3'b000, 5'd0), 0, 5'd0, 32'd0, 3'b000));
      vecs.push_back(mk("xori_x14", i_t(12'h0FF, 5'd1, 3'b100, 5'd14), 0, 5'd14, 32'h0000_00F5, 3'b100));
      vecs.push_back(mk("ori_x15", i_t(12'h800, 5'd2, 3'b110, 5'd15), 0, 5'd15, 32'hFFFF_F805, 3'b011));
      vecs.push_back(mk("andi_x16", i_t(12'hFFF, 5'd10, 3'b111, 5'd16), 0, 5'd16, 32'hFFFF_FFF8, 3'b010));
      vecs.push_back(mk("slli_x17", i_t(12'h004, 5'd1, 3'b001, 5'd17), 0, 5'd17, 32'd160, 3'b101));
      vecs.push_back(mk("srli_x18", i_t(12'h01C, 5'd10, 3'b101, 5'd18), 0, 5'd18, 32'h0000_000F, 3'b110));
      vecs.push_back(mk("sll_rs2full", r_t(7'h00, 5'd10, 5'd1, 3'b001, 5'd19), 0, 5'd19,
                        32'h0A00_0000, 3'b101));
      vecs.push_back(mk("sra_x20", r_t(7'h20, 5'd2, 5'd10, 3'b101, 5'd20), !sra_en, 5'd20,
                        32'hFFFF_FFFF, 3'b111));
      vecs.push_back(mk("sltiu_x21", i_t(12'd1, 5'd1, 3'b011, 5'd21), 1, 5'd21, 32'd0, 3'b000));
      vecs.push_back(mk("lui_ill", 32'h0000_10B7, 1, 5'd1, 32'd0, 3'b000));
      vecs.push_back(mk("mul_ill", r_t(7'h01, 5'd2, 5'd1, 3'b000, 5'd22), 1, 5'd22, 32'd0, 3'b000));
      vecs.push_back(mk("slli_badf7", i_t(12'h401, 5'd1, 3'b001, 5'd23), 1, 5'd23, 32'd0, 3'b000));
      vecs.push_back(mk("addi_x1_self", i_t(12'd1, 5'd1, 3'b000, 5'd1), 0, 5'd1, 32'd11, 3'b000));
      vecs.push_back(mk("add_x24_x1x1", r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd24), 0, 5'd24, 32'd22, 3'b000));

      rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", 32'(instr_ready), 32'd0);
      chk("rst.alu_a", alu_a, 32'd0);
      chk("rst.alu_b", alu_b, 32'd0);
      chk("rst.alu_op", 32'(alu_op), 32'd0);
      chk("rst.pulses", {30'd0, done_valid, illegal}, 32'd0);
      chk("rst.done_rd", 32'(done_rd), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst.ready_after", 32'(instr_ready), 32'd1);

      foreach (vecs[i]) issue(vecs[i]);

      dbg_addr = 5'd0; #1;
      chk("x0.read", dbg_data, 32'd0);

      // Reset while ADD x13 is in EXEC.
      instr = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd13);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst.done", 32'(done_valid), 32'd0);
      chk("midrst.ready_low", 32'(instr_ready), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      @(posedge clk); #1;
      chk("midrst.ready_high", 32'(instr_ready), 32'd1);
      chk("midrst.done2", 32'(done_valid), 32'd0);
      dbg_addr = 5'd13; #1;
      chk("midrst.x13", dbg_data, 32'd0);
      dbg_addr = 5'd1; #1;
      chk("midrst.x1", dbg_data, 32'd0);
      chk("midrst.done_count", 32'(done_cnt), 32'(exp_done));
      issue(mk("post_rst_addi", i_t(12'd3, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'd3, 3'b000));

      repeat (2) @(posedge clk);
      #1;
      chk("done_count", 32'(done_cnt), 32'(exp_done));
      if (!sra_en) chk("no_op7", 32'(saw_op7), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
